// File: rtl/mul_sequencer.sv
// Iterative 32-bit shift-add multiplier that stalls the EX stage until the product is ready.
// Optional build macro MUL_EARLY_TERM_EN ends the iteration once the remaining multiplier is zero.
//
// state | meaning
// IDLE  | no multiply in progress; a valid MUL in EX starts one
// BUSY  | one shift-add iteration per cycle
// DONE  | one cycle; result presented, stall released
module mul_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [3:0]  ALUCtrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam logic [3:0] MUL_CODE = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] mcand, mcand_nxt;
  logic [31:0] mplier, mplier_nxt;
  logic [31:0] result_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        start;
  logic        last_iter;

  assign start = valid_i && (ALUCtrl_i == MUL_CODE);

`ifdef MUL_EARLY_TERM_EN
  // The bits still to be consumed after this shift are mplier[31:1]
  assign last_iter = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
`else
  assign last_iter = (cnt == 5'd31);
`endif

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    cnt_nxt    = cnt;
    result_nxt = result_o;
    case (state)
      S_IDLE: begin
        if (start) begin
          mcand_nxt  = src1_i;
          mplier_nxt = src2_i;
          acc_nxt    = 32'd0;
          cnt_nxt    = 5'd0;
          state_nxt  = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mcand_nxt  = {mcand[30:0], 1'b0};
        mplier_nxt = {1'b0, mplier[31:1]};
        cnt_nxt    = cnt + 5'd1;
        if (last_iter) begin
          result_nxt = acc_nxt;
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      acc      <= 32'd0;
      mcand    <= 32'd0;
      mplier   <= 32'd0;
      cnt      <= 5'd0;
      result_o <= 32'd0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      mcand    <= mcand_nxt;
      mplier   <= mplier_nxt;
      cnt      <= cnt_nxt;
      result_o <= result_nxt;
    end
  end

  // Stall is combinational so the MUL is held in the very cycle it reaches EX
  assign stall_o = ((state == S_IDLE) && start) || (state == S_BUSY);
  assign busy_o  = (state == S_BUSY);
  assign done_o  = (state == S_DONE);

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed and random multiplies against an arithmetic model.
module tb_mul_sequencer;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  ALUCtrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks;
  int failures;
  logic [31:0] exp_result;

  mul_sequencer dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ALUCtrl_i(ALUCtrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Total stall cycles for a MUL (start cycle plus BUSY cycles)
  function automatic int exp_stall_cycles(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int msb;
    msb = 0;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i + 1;
    return 1 + ((msb < 1) ? 1 : msb);
`else
    return 33;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    valid_i   = 1'b0;
    ALUCtrl_i = 4'b0000;
    src1_i    = 32'd0;
    src2_i    = 32'd0;
  endtask

  task automatic drive_noise();
    valid_i   = 1'($urandom);
    ALUCtrl_i = 4'($urandom);
    src1_i    = $urandom;
    src2_i    = $urandom;
  endtask

  // Issues one MUL at the next cycle and checks every cycle through DONE.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] prod;
    prod = a * b;
    lat  = exp_stall_cycles(b);
    tick();
    valid_i = 1'b1; ALUCtrl_i = 4'b0101; src1_i = a; src2_i = b;
    #1;
    checks++;
    if ({stall_o, busy_o, done_o} !== 3'b100) begin
      failures++;
      $display("FAIL %s start: stall/busy/done=%b expected 100", name, {stall_o, busy_o, done_o});
    end
    for (int k = 1; k < lat; k++) begin
      tick();
      drive_noise();
      #1;
      checks++;
      if ({stall_o, busy_o, done_o} !== 3'b110) begin
        failures++;
        $display("FAIL %s busy T+%0d: stall/busy/done=%b expected 110", name, k, {stall_o, busy_o, done_o});
      end
    end
    tick();
    drive_noise();
    #1;
    checks++;
    if ({stall_o, busy_o, done_o} !== 3'b001) begin
      failures++;
      $display("FAIL %s done T+%0d: stall/busy/done=%b expected 001", name, lat, {stall_o, busy_o, done_o});
    end
    checks++;
    if (result_o !== prod) begin
      failures++;
      $display("FAIL %s result: got %h expected %h", name, result_o, prod);
    end
    exp_result = prod;
  endtask

  task automatic settle();
    tick();
    drive_idle();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive_idle();
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({stall_o, busy_o, done_o} !== 3'b000 || result_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: stall/busy/done=%b result=%h expected 000 and 0", {stall_o, busy_o, done_o}, result_o);
    end
    exp_result = 32'd0;
  endtask

  task automatic test_directed();
    run_mul("mul_6x7", 32'd6, 32'd7);
    run_mul("mul_ffff_x2", 32'hFFFFFFFF, 32'h00000002);
    run_mul("mul_wrap", 32'h80000000, 32'h80000000);
    run_mul("mul_5x3", 32'd5, 32'd3);
    run_mul("mul_5x0", 32'd5, 32'd0);
    settle();
  endtask

  task automatic test_non_mul();
    for (int k = 0; k < 12; k++) begin
      tick();
      src1_i = $urandom; src2_i = $urandom;
      if (k == 0)      begin valid_i = 1'b1; ALUCtrl_i = 4'b0011; end
      else if (k == 1) begin valid_i = 1'b1; ALUCtrl_i = 4'b0100; end
      else if (k == 2) begin valid_i = 1'b0; ALUCtrl_i = 4'b0101; end
      else begin
        valid_i   = 1'($urandom);
        ALUCtrl_i = 4'($urandom);
        if (valid_i && ALUCtrl_i == 4'b0101) ALUCtrl_i = 4'b0011;
      end
      #1;
      checks++;
      if ({stall_o, busy_o, done_o} !== 3'b000 || result_o !== exp_result) begin
        failures++;
        $display("FAIL non_mul %0d: stall/busy/done=%b result=%h expected 000 and %h", k, {stall_o, busy_o, done_o}, result_o, exp_result);
      end
    end
    settle();
  endtask

  task automatic test_back_to_back();
    run_mul("b2b_3x5", 32'd3, 32'd5);
    run_mul("b2b_9x9", 32'd9, 32'd9);
    settle();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_mul("random", a, b);
    end
    settle();
  endtask

  task automatic test_reset_mid_op();
    tick();
    valid_i = 1'b1; ALUCtrl_i = 4'b0101; src1_i = 32'h12345678; src2_i = 32'h80000001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      drive_noise();
    end
    tick();
    rst_i = 1'b1;
    drive_idle();
    tick();
    rst_i = 1'b0;
    #1;
    checks++;
    if ({stall_o, busy_o, done_o} !== 3'b000 || result_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_op T+11: stall/busy/done=%b result=%h expected 000 and 0", {stall_o, busy_o, done_o}, result_o);
    end
    exp_result = 32'd0;
    for (int k = 0; k < 30; k++) begin
      tick();
      #1;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done %0d: busy=%b done=%b expected 0 0", k, busy_o, done_o);
      end
    end
    // Reset wins over a simultaneous start
    tick();
    rst_i = 1'b1;
    valid_i = 1'b1; ALUCtrl_i = 4'b0101; src1_i = 32'd2; src2_i = 32'd2;
    tick();
    rst_i = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority: busy=%b stall=%b expected 0 0", busy_o, stall_o);
    end
    settle();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_result = 32'd0;
    rst_i      = 1'b1;
    drive_idle();
    test_reset();
    test_directed();
    test_non_mul();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    test_non_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle shift-add multiplier sequencer for the EX stage of the pipelined RV32 core. It detects a MUL in EX (ALU control code 4'b0101) and runs a 32-bit iterative multiply. It holds the pipeline with a stall until the product is ready, then releases it with the product on a dedicated result port. EX muxes `result_o` over the single-cycle ALU output when `done_o` is high.

## Interface
- No parameters; operand width fixed at 32.
- `clk_i` in 1: clock; all state updates on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `valid_i` in 1: EX stage holds a valid (non-bubble) instruction.
- `ALUCtrl_i` in 4: ALU control code of the EX instruction; 4'b0101 = MUL.
- `src1_i` in 32: rs1 operand (multiplicand).
- `src2_i` in 32: rs2 operand (multiplier).
- `stall_o` out 1: freeze PC, IF/ID, ID/EX and EX/MEM; bubble-free hold.
- `busy_o` out 1: high in BUSY state.
- `done_o` out 1: one-cycle strobe; `result_o` valid this cycle.
- `result_o` out 32: low 32 bits of `src1 * src2`.

## Operation
- States:
  - IDLE: no multiply in progress.
  - BUSY: one shift-add iteration per cycle.
  - DONE: one cycle; presents the result and releases the stall.
- Start condition, evaluated in IDLE only: `start = valid_i && ALUCtrl_i == 4'b0101`.
- IDLE with start:
  - Latch `mcand <= src1_i`, `mplier <= src2_i`, `acc <= 0`, `cnt <= 0`.
  - Go to BUSY.
- IDLE without start: stay in IDLE; registers hold.
- BUSY iteration, each cycle:
  - If `mplier[0]`, `acc <= acc + mcand`, mod 2^32.
  - `mcand <= mcand << 1` (32-bit, MSB discarded).
  - `mplier <= mplier >> 1` (logical).
  - `cnt <= cnt + 1` (5-bit).
- BUSY exit: when `cnt == 31`, go to DONE after that iteration is applied.
- DONE:
  - `result_o <= final acc`.
  - Go to IDLE unconditionally; `valid_i` and `ALUCtrl_i` are ignored, since the MUL is still in EX this cycle.
- `valid_i`, `ALUCtrl_i` and the operands are ignored in BUSY and DONE. Operand inputs may change freely after the start cycle.
- Signed and unsigned operands give identical low-32 results; no sign handling is needed.
- `result_o` holds its value until the next DONE.
- A non-MUL code or `valid_i=0` never affects state or outputs.

## Timing
- `stall_o = (IDLE && start) || BUSY`. It is combinational so it is asserted in the same cycle the MUL enters EX.
- `busy_o = BUSY` (registered state decode).
- `done_o = DONE` (registered state decode).
- Start in cycle T (IDLE), without the early-termination feature:
  - Cycles T+1..T+32: BUSY.
  - Cycle T+33: DONE.
  - `stall_o` is high T..T+32 (33 cycles) and low at T+33.
  - The pipeline advances at the end of T+33.
- Back-to-back MULs: the second MUL enters EX at T+34 in IDLE and starts immediately; there is no dead cycle beyond DONE.
- Reset values: state IDLE, `acc`/`mcand`/`mplier`/`cnt` 0, `result_o` 0, `stall_o` 0, `busy_o` 0, `done_o` 0.
- Reset mid-operation (BUSY or DONE):
  - Next cycle is IDLE with all registers zero.
  - No `done_o` is issued.
  - `stall_o` drops in that cycle, unless start is true at that IDLE.
- Reset has priority over start in the same cycle.

## Configuration
- `MUL_EARLY_TERM_EN` defined:
  - BUSY also exits to DONE when the post-shift multiplier is zero, i.e. `mplier[31:1] == 0` during the iteration.
  - Minimum one BUSY cycle, even when `src2 == 0`.
  - Latency is `1 + max(1, bit position of MSB of src2 + 1)` stall cycles.
  - DONE follows immediately after the last BUSY cycle.
- `MUL_EARLY_TERM_EN` undefined: fixed 32 BUSY cycles as above; the zero check logic is absent.

## Test plan
- MUL `src1=6`, `src2=7` at T, no macro:
  - `stall_o` high T..T+32.
  - `done_o=1`, `result_o=42` at T+33.
  - `stall_o=0` at T+33.
- MUL `0xFFFFFFFF * 0x00000002` -> `result_o=0xFFFFFFFE`.
- MUL `0x80000000 * 0x80000000` -> `result_o=0x00000000` (wrap).
- ADD (4'b0011) and SUB (4'b0100) with `valid_i=1`, then MUL with `valid_i=0`:
  - `stall_o`, `busy_o` and `done_o` stay 0.
  - `result_o` unchanged.
- Two MULs back-to-back, `3*5` then `9*9`:
  - `done_o` at T+33 with 15.
  - Second start at T+34.
  - `done_o` at T+67 with 81.
- Assert `rst_i` at T+10 during BUSY:
  - T+11: IDLE, `stall_o=0`, `result_o=0`.
  - No `done_o` pulse for that operation.
- With `MUL_EARLY_TERM_EN`:
  - `5*3`: BUSY at T+1..T+2, `done_o` at T+3, `result_o=15`.
  - `5*0`: `done_o` at T+2, `result_o=0`.
